// File: rtl/sysid_pkg.sv
// Shared types and constants for the boot-time system-ID checker.
// Imported by sysid_checker.
package sysid_pkg;

  localparam int SYSID_DW = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RD_ID   = 3'd2,
    S_RD_TS   = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/sysid_checker.sv
// Reads ID and timestamp from the sysid slave at boot and compares them
// against build-time values; result gates software release and LEDs.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [SYSID_DW-1:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [SYSID_DW-1:0] EXPECTED_TS  = 32'h5AA9_79AC,
  parameter bit                  CHECK_TS     = 1'b1,
  parameter int                  READ_LATENCY = 0,
  parameter bit                  AUTO_START   = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                sysid_address,
  input  logic [SYSID_DW-1:0] sysid_readdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                id_mismatch,
  output logic                ts_mismatch,
  output logic [SYSID_DW-1:0] captured_id,
  output logic [SYSID_DW-1:0] captured_ts
);

  if (READ_LATENCY < 0 || READ_LATENCY > 15) begin : g_lat_chk
    $error("sysid_checker: READ_LATENCY must be 0..15");
  end

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                auto_q, auto_d;
  logic                addr_d;
  logic                busy_d, done_d, pass_d;
  logic                idm_d, tsm_d;
  logic [SYSID_DW-1:0] cid_d, cts_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    auto_d  = auto_q;
    addr_d  = sysid_address;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    idm_d   = id_mismatch;
    tsm_d   = ts_mismatch;
    cid_d   = captured_id;
    cts_d   = captured_ts;
    unique case (state_q)
      S_IDLE: begin
        // auto_q acts as a one-shot start on the first clock after reset
        auto_d = 1'b0;
        if (start || auto_q) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        idm_d   = 1'b0;
        tsm_d   = 1'b0;
        addr_d  = SYSID_ADDR_ID;
        cnt_d   = '0;
        state_d = S_RD_ID;
      end
      S_RD_ID: begin
        if (cnt_q == LAT) begin
          cid_d   = sysid_readdata;
          addr_d  = SYSID_ADDR_TS;
          cnt_d   = '0;
          state_d = S_RD_TS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RD_TS: begin
        if (cnt_q == LAT) begin
          cts_d   = sysid_readdata;
          addr_d  = SYSID_ADDR_ID;
          cnt_d   = '0;
          state_d = S_COMPARE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_COMPARE: begin
        idm_d   = (captured_id != EXPECTED_ID);
        tsm_d   = (captured_ts != EXPECTED_TS);
        pass_d  = !idm_d && !(CHECK_TS && tsm_d);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = S_LAUNCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      auto_q        <= AUTO_START;
      sysid_address <= SYSID_ADDR_ID;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      id_mismatch   <= 1'b0;
      ts_mismatch   <= 1'b0;
      captured_id   <= '0;
      captured_ts   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      auto_q        <= auto_d;
      sysid_address <= addr_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      id_mismatch   <= idm_d;
      ts_mismatch   <= tsm_d;
      captured_id   <= cid_d;
      captured_ts   <= cts_d;
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: three instances covering defaults,
// CHECK_TS=0, and READ_LATENCY=3 with AUTO_START=0.
module tb_sysid_checker;
  import sysid_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  start_v = '0;
  logic [2:0]  addr_v, busy_v, done_v;
  logic [2:0]  pass_v, idm_v, tsm_v;
  logic [31:0] rd_v  [3];
  logic [31:0] cid_v [3];
  logic [31:0] cts_v [3];
  logic [31:0] id_val [3];
  logic [31:0] ts_val [3];

  logic        aq_c  = 1'b0;
  int          age_c = 0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic        pass;
    logic        idm;
    logic        tsm;
    logic [31:0] cid;
    logic [31:0] cts;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clock = ~clock;

  // Zero-latency slaves
  assign rd_v[0] = addr_v[0] ? ts_val[0] : id_val[0];
  assign rd_v[1] = addr_v[1] ? ts_val[1] : id_val[1];

  // Slave with 3-cycle read latency; garbage until data settles
  always @(posedge clock) begin
    aq_c  <= addr_v[2];
    age_c <= (addr_v[2] != aq_c) ? 1 : ((age_c >= 15) ? 15 : age_c + 1);
  end
  assign rd_v[2] = (addr_v[2] == aq_c && age_c >= 3)
                 ? (addr_v[2] ? ts_val[2] : id_val[2])
                 : 32'hDEAD_BEEF;

  sysid_checker u_a (
    .clock          (clock),
    .reset          (reset),
    .start          (start_v[0]),
    .sysid_address  (addr_v[0]),
    .sysid_readdata (rd_v[0]),
    .busy           (busy_v[0]),
    .done           (done_v[0]),
    .pass           (pass_v[0]),
    .id_mismatch    (idm_v[0]),
    .ts_mismatch    (tsm_v[0]),
    .captured_id    (cid_v[0]),
    .captured_ts    (cts_v[0])
  );

  sysid_checker #(
    .CHECK_TS (1'b0)
  ) u_b (
    .clock          (clock),
    .reset          (reset),
    .start          (start_v[1]),
    .sysid_address  (addr_v[1]),
    .sysid_readdata (rd_v[1]),
    .busy           (busy_v[1]),
    .done           (done_v[1]),
    .pass           (pass_v[1]),
    .id_mismatch    (idm_v[1]),
    .ts_mismatch    (tsm_v[1]),
    .captured_id    (cid_v[1]),
    .captured_ts    (cts_v[1])
  );

  sysid_checker #(
    .EXPECTED_ID  (32'h1234_5678),
    .READ_LATENCY (3),
    .AUTO_START   (1'b0)
  ) u_c (
    .clock          (clock),
    .reset          (reset),
    .start          (start_v[2]),
    .sysid_address  (addr_v[2]),
    .sysid_readdata (rd_v[2]),
    .busy           (busy_v[2]),
    .done           (done_v[2]),
    .pass           (pass_v[2]),
    .id_mismatch    (idm_v[2]),
    .ts_mismatch    (tsm_v[2]),
    .captured_id    (cid_v[2]),
    .captured_ts    (cts_v[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic p,
                      input logic im, input logic tm,
                      input logic [31:0] ci, input logic [31:0] ct,
                      input int lat);
    exp_t e;
    e.tag  = tag;
    e.pass = p;
    e.idm  = im;
    e.tsm  = tm;
    e.cid  = ci;
    e.cts  = ct;
    e.lat  = lat;
    sb_q.push_back(e);
  endtask

  // Counts edges from the one sampling start (or reset release) until
  // done rises; optionally pulses start again at edge count restart_at.
  task automatic wait_done(input int d, input int restart_at);
    exp_t e;
    int   n;
    int   rises;
    int   falls;
    bit   low;
    logic pa;
    e     = sb_q.pop_front();
    n     = 0;
    rises = 0;
    falls = 0;
    low   = 1'b0;
    pa    = addr_v[d];
    while (n < 60) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      start_v[d] = 1'b0;
      if (n == restart_at) start_v[d] = 1'b1;
      if (addr_v[d] && !pa) rises++;
      if (!addr_v[d] && pa) falls++;
      pa = addr_v[d];
      if (!done_v[d]) low = 1'b1;
      else if (low) break;
    end
    start_v[d] = 1'b0;
    chk({e.tag, "/lat"},   32'(n),       32'(e.lat));
    chk({e.tag, "/pass"},  32'(pass_v[d]), 32'(e.pass));
    chk({e.tag, "/idm"},   32'(idm_v[d]),  32'(e.idm));
    chk({e.tag, "/tsm"},   32'(tsm_v[d]),  32'(e.tsm));
    chk({e.tag, "/cid"},   cid_v[d],     e.cid);
    chk({e.tag, "/cts"},   cts_v[d],     e.cts);
    chk({e.tag, "/busy"},  32'(busy_v[d]), 32'd0);
    chk({e.tag, "/rise"},  32'(rises),   32'd1);
    chk({e.tag, "/fall"},  32'(falls),   32'd1);
  endtask

  initial begin
    id_val[0] = 32'h0;
    id_val[1] = 32'h0;
    id_val[2] = 32'h1234_5678;
    ts_val[0] = 32'h5AA9_79AC;
    ts_val[1] = 32'h5AA9_79AC;
    ts_val[2] = 32'h5AA9_79AC;

    repeat (2) @(negedge clock);
    chk("rst/busy", 32'(busy_v[0]), 32'd0);
    chk("rst/done", 32'(done_v[0]), 32'd0);
    chk("rst/pass", 32'(pass_v[0]), 32'd0);
    chk("rst/idm",  32'(idm_v[0]),  32'd0);
    chk("rst/tsm",  32'(tsm_v[0]),  32'd0);
    chk("rst/addr", 32'(addr_v[0]), 32'd0);
    chk("rst/cid",  cid_v[0],       32'd0);
    chk("rst/cts",  cts_v[0],       32'd0);

    push("auto", 1'b1, 1'b0, 1'b0, 32'h0, 32'h5AA9_79AC, 5);
    reset = 1'b0;
    wait_done(0, 0);
    chk("c_idle/busy", 32'(busy_v[2]), 32'd0);
    chk("c_idle/done", 32'(done_v[2]), 32'd0);

    id_val[0] = 32'h1;
    push("bad_id", 1'b0, 1'b1, 1'b0, 32'h1, 32'h5AA9_79AC, 5);
    start_v[0] = 1'b1;
    wait_done(0, 0);

    id_val[0] = 32'h0;
    ts_val[0] = 32'h5AA9_79AD;
    push("bad_ts", 1'b0, 1'b0, 1'b1, 32'h0, 32'h5AA9_79AD, 5);
    start_v[0] = 1'b1;
    wait_done(0, 0);

    ts_val[1] = 32'h5AA9_79AD;
    push("ts_ign", 1'b1, 1'b0, 1'b1, 32'h0, 32'h5AA9_79AD, 5);
    start_v[1] = 1'b1;
    wait_done(1, 0);

    push("lat3", 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h5AA9_79AC, 11);
    start_v[2] = 1'b1;
    wait_done(2, 0);

    push("busy_st", 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h5AA9_79AC, 11);
    start_v[2] = 1'b1;
    wait_done(2, 3);

    // Abort in RD_TS with an asynchronous reset
    start_v[2] = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clock);
      @(negedge clock);
      start_v[2] = 1'b0;
    end
    chk("mid/busy", 32'(busy_v[2]), 32'd1);
    chk("mid/addr", 32'(addr_v[2]), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst/busy", 32'(busy_v[2]), 32'd0);
    chk("arst/addr", 32'(addr_v[2]), 32'd0);
    chk("arst/done", 32'(done_v[2]), 32'd0);
    chk("arst/pass", 32'(pass_v[2]), 32'd0);
    chk("arst/cid",  cid_v[2],       32'd0);
    chk("arst/cts",  cts_v[2],       32'd0);
    chk("arst/a_done", 32'(done_v[0]), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("idle2/busy", 32'(busy_v[2]), 32'd0);
    chk("idle2/done", 32'(done_v[2]), 32'd0);
    chk("idle2/cid",  cid_v[2],       32'd0);

    push("after_rst", 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h5AA9_79AC, 11);
    start_v[2] = 1'b1;
    wait_done(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
